// File: rtl/alu_seq.sv
// Command sequencer for the 32-bit ALU: runs 32-bit ops in one ALU pass and
// 64-bit add/sub/compare as two carry-chained passes, with valid/ready on both sides.
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_y,
  output logic [3:0]  res_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_imm,
  output logic        alu_src,
  output logic        alu_bsel,
  output logic        alu_cisel,
  output logic        alu_logical_oa,
  output logic        alu_logicalop,
  input  logic [31:0] alu_y,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_z
);

  localparam int unsigned AluW  = 32;
  localparam int unsigned OpndW = 64;
  localparam int unsigned FlagW = 4;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_ADDI  = 3'b100,
    OP_ADD64 = 3'b101,
    OP_SUB64 = 3'b110,
    OP_CMP64 = 3'b111
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [OpndW-1:0]   a_q, a_d;
  logic [OpndW-1:0]   b_q, b_d;
  logic [OpndW-1:0]   y_q, y_d;
  logic [FlagW-1:0]   flags_q, flags_d;
  logic               is_wide;
  logic               is_sub;
  logic               is_cmp;

  assign res_y     = y_q;
  assign res_flags = flags_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  // Next state, result capture and ALU control decode.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    y_d            = y_q;
    flags_d        = flags_q;
    cmd_ready      = 1'b0;
    res_valid      = 1'b0;
    alu_a          = '0;
    alu_b          = '0;
    alu_imm        = '0;
    alu_src        = 1'b0;
    alu_bsel       = 1'b0;
    alu_cisel      = 1'b0;
    alu_logical_oa = 1'b0;
    alu_logicalop  = 1'b0;

    is_wide = (op_q == OP_ADD64) || (op_q == OP_SUB64) || (op_q == OP_CMP64);
    is_sub  = (op_q == OP_SUB) || (op_q == OP_SUB64) || (op_q == OP_CMP64);
    is_cmp  = (op_q == OP_CMP64);

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = ST_LO;
        end
      end

      ST_LO: begin
        alu_a = a_q[AluW-1:0];
        alu_b = b_q[AluW-1:0];
        case (op_q)
          OP_SUB, OP_SUB64, OP_CMP64: begin
            alu_bsel  = 1'b1;
            alu_cisel = 1'b1;
          end
          OP_AND: alu_logicalop = 1'b1;
          OP_OR: begin
            alu_logicalop  = 1'b1;
            alu_logical_oa = 1'b1;
          end
          OP_ADDI: begin
            alu_src = 1'b1;
            alu_imm = b_q[AluW-1:0];
          end
          default: ;
        endcase
        y_d     = is_cmp ? '0 : {AluW'(0), alu_y};
        flags_d = {alu_n, alu_z, alu_c, alu_v};
        state_d = is_wide ? ST_HI : ST_DONE;
      end

      ST_HI: begin
        // Upper half chains the carry captured from the lower pass.
        alu_a     = a_q[OpndW-1:AluW];
        alu_b     = b_q[OpndW-1:AluW];
        alu_bsel  = is_sub;
        alu_cisel = flags_q[FlagC];
        y_d[OpndW-1:AluW] = is_cmp ? '0 : alu_y;
        flags_d = {alu_n, flags_q[FlagZ] & alu_z, alu_c, alu_v};
        state_d = ST_DONE;
      end

      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU attached to the sequencer, directed
// vector table, randomized commands against an arithmetic reference, and corner sequences.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [63:0] cmd_a, cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_y;
  logic [3:0]  res_flags;
  logic [31:0] alu_a, alu_b, alu_imm;
  logic        alu_src, alu_bsel, alu_cisel, alu_logical_oa, alu_logicalop;
  logic [31:0] alu_y;
  logic        alu_c, alu_v, alu_n, alu_z;

  int checks   = 0;
  int failures = 0;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_flags(res_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
    .alu_src(alu_src), .alu_bsel(alu_bsel), .alu_cisel(alu_cisel),
    .alu_logical_oa(alu_logical_oa), .alu_logicalop(alu_logicalop),
    .alu_y(alu_y), .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU: B operand (or immediate), optional invert, carry-in.
  logic [31:0] bb;
  logic [32:0] sum;
  always_comb begin
    bb = alu_src ? alu_imm : alu_b;
    if (alu_bsel) bb = ~bb;
    sum = {1'b0, alu_a} + {1'b0, bb} + {32'b0, alu_cisel};
    if (alu_logicalop) begin
      alu_y = alu_logical_oa ? (alu_a | alu_b) : (alu_a & alu_b);
      alu_c = 1'b0;
      alu_v = 1'b0;
    end else begin
      alu_y = sum[31:0];
      alu_c = sum[32];
      alu_v = (alu_a[31] == bb[31]) && (sum[31] != alu_a[31]);
    end
    alu_n = alu_y[31];
    alu_z = (alu_y == 32'd0);
  end

  // Reference: exact wide arithmetic, flags from the mathematical result.
  function automatic void ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] y, output logic [3:0] f);
    logic wide, sub;
    logic [65:0] ua, ub, us;
    logic signed [65:0] sa, sb, ss;
    logic [63:0] r;
    logic n, z, c, v;
    wide = (op >= 3'd5);
    sub  = (op == 3'd1) || (op == 3'd6) || (op == 3'd7);
    if (wide) begin
      ua = {2'b0, a};  ub = {2'b0, b};
      sa = $signed({{2{a[63]}}, a});  sb = $signed({{2{b[63]}}, b});
    end else begin
      ua = {34'b0, a[31:0]};  ub = {34'b0, b[31:0]};
      sa = $signed({{34{a[31]}}, a[31:0]});  sb = $signed({{34{b[31]}}, b[31:0]});
    end
    if (sub) begin
      us = ua - ub;  ss = sa - sb;  c = (ua >= ub);
    end else begin
      us = ua + ub;  ss = sa + sb;  c = wide ? us[64] : us[32];
    end
    v = wide ? (ss[64] != ss[63]) : (ss[32] != ss[31]);
    r = wide ? us[63:0] : {32'b0, us[31:0]};
    if (op == 3'd2 || op == 3'd3) begin
      r = {32'b0, (op == 3'd2) ? (a[31:0] & b[31:0]) : (a[31:0] | b[31:0])};
      c = 1'b0;
      v = 1'b0;
    end
    n = wide ? r[63] : r[31];
    z = (r == 64'd0);
    y = (op == 3'd7) ? 64'd0 : r;
    f = {n, z, c, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one command from IDLE (#1 after a posedge), hold the result `stall`
  // cycles, then hand it off. Returns at #1 after the handshake edge.
  task automatic run_cmd(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int stall, output logic [63:0] y, output logic [3:0] f,
                         output int lat, output logic lo_rdy, output logic lo_src,
                         output logic [31:0] lo_imm);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_a     = {$urandom, $urandom};
    cmd_b     = {$urandom, $urandom};
    lo_rdy = cmd_ready;
    lo_src = alu_src;
    lo_imm = alu_imm;
    lat = 0;
    while (!res_valid && lat < 16) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!res_valid) begin
      chk("timeout_res_valid", 64'(res_valid), 64'd1);
      y = 'x;
      f = 'x;
      return;
    end
    y = res_y;
    f = res_flags;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 64'(res_valid), 64'd1);
      chk("stall_y", res_y, y);
      chk("stall_flags", 64'(res_flags), 64'(f));
      chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("post_hs_valid", 64'(res_valid), 64'd0);
    chk("post_hs_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] y;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [63:0] y, ey;
    logic [3:0]  f, ef;
    logic        lrdy, lsrc;
    logic [31:0] limm;
    logic [2:0]  op;
    logic [63:0] a, b;
    int          lat;

    // {op, a, b, expected y, expected {N,Z,C,V}}
    vecs[0]  = '{3'd0, 64'd5, 64'd7, 64'd12, 4'b0000};
    vecs[1]  = '{3'd1, 64'd3, 64'd3, 64'd0, 4'b0110};
    vecs[2]  = '{3'd1, 64'd0, 64'd1, 64'h0000_0000_FFFF_FFFF, 4'b1000};
    vecs[3]  = '{3'd5, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 4'b0000};
    vecs[4]  = '{3'd7, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'b0110};
    vecs[5]  = '{3'd0, 64'h7FFF_FFFF, 64'd1, 64'h8000_0000, 4'b1001};
    vecs[6]  = '{3'd3, 64'hF0, 64'h0F, 64'hFF, 4'b0000};
    vecs[7]  = '{3'd4, 64'd10, 64'hFFFF_FFFF, 64'd9, 4'b0010};
    vecs[8]  = '{3'd2, 64'hFFFF_FFFF_0000_FF00, 64'h1234_5678_0F0F_0F0F, 64'h0F00, 4'b0000};
    vecs[9]  = '{3'd6, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[10] = '{3'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'b0111};
    vecs[11] = '{3'd0, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0110};

    rst_n = 1'b0;  cmd_valid = 1'b0;  cmd_op = '0;  cmd_a = '0;  cmd_b = '0;  res_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_y", res_y, 64'd0);
    chk("rst_res_flags", 64'(res_flags), 64'd0);
    chk("rst_alu_ctl", {alu_a, alu_b}, 64'd0);
    chk("rst_alu_misc", {alu_imm, 27'd0, alu_src, alu_bsel, alu_cisel, alu_logical_oa, alu_logicalop}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // res_ready with no result pending is a no-op.
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("idle_rr_valid", 64'(res_valid), 64'd0);
    chk("idle_rr_ready", 64'(cmd_ready), 64'd1);

    // Directed table; LO+DONE for 32-bit ops, LO+HI+DONE for 64-bit ops.
    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 0, y, f, lat, lrdy, lsrc, limm);
      chk($sformatf("vec%0d_y", i), y, vecs[i].y);
      chk($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].f));
      chk($sformatf("vec%0d_lat", i), 64'(lat), (vecs[i].op >= 3'd5) ? 64'd2 : 64'd1);
      chk($sformatf("vec%0d_lo_ready", i), 64'(lrdy), 64'd0);
      chk($sformatf("vec%0d_lo_src", i), 64'(lsrc), (vecs[i].op == 3'd4) ? 64'd1 : 64'd0);
      chk($sformatf("vec%0d_lo_imm", i), 64'(limm),
          (vecs[i].op == 3'd4) ? {32'd0, vecs[i].b[31:0]} : 64'd0);
    end

    // Randomized commands with corner-biased operands.
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = a;
        1: a[62:0] = '1;
        2: b[31:0] = a[31:0];
        default: ;
      endcase
      ref_model(op, a, b, ey, ef);
      run_cmd(op, a, b, 0, y, f, lat, lrdy, lsrc, limm);
      chk($sformatf("rnd%0d_op%0d_y", i, op), y, ey);
      chk($sformatf("rnd%0d_op%0d_flags", i, op), 64'(f), 64'(ef));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), (op >= 3'd5) ? 64'd2 : 64'd1);
    end

    // Stall in DONE for 5 cycles with a 64-bit result.
    ref_model(3'd6, 64'h1_0000_0000, 64'h2, ey, ef);
    run_cmd(3'd6, 64'h1_0000_0000, 64'h2, 5, y, f, lat, lrdy, lsrc, limm);
    chk("stall_res_y", y, ey);
    chk("stall_res_flags", 64'(f), 64'(ef));

    // Reset asserted while the upper half of an ADD64 is on the ALU.
    cmd_valid = 1'b1;  cmd_op = 3'd5;
    cmd_a = 64'h1234_5678_FFFF_FFFF;  cmd_b = 64'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("hi_alu_a", 64'(alu_a), 64'h1234_5678);
    chk("hi_alu_cisel", 64'(alu_cisel), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(res_valid), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("abort_alu_a", 64'(alu_a), 64'd0);
    chk("abort_res_y", res_y, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("after_abort_valid", 64'(res_valid), 64'd0);
    chk("after_abort_ready", 64'(cmd_ready), 64'd1);

    run_cmd(3'd0, 64'd100, 64'd23, 0, y, f, lat, lrdy, lsrc, limm);
    chk("recover_y", y, 64'd123);
    chk("recover_flags", 64'(f), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
